// File: rtl/ysyx_220053_pkg.sv
// Shared definitions for the ysyx_220053 instruction fetch unit.
//   - default address width and reset PC
//   - canonical NOP encoding (addi x0, x0, 0) held on instr_o after reset
//   - fetch FSM state encoding
package ysyx_220053_pkg;

    localparam int          ADDR_W_DEFAULT   = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE = 2'd0;  // one cycle after reset, no request
    localparam fetch_state_t S_REQ  = 2'd1;  // presenting request to imem
    localparam fetch_state_t S_WAIT = 2'd2;  // request accepted, awaiting response
    localparam fetch_state_t S_HOLD = 2'd3;  // instruction held for the decoder

endpackage

// File: rtl/ysyx_220053_pc_gen.sv
// Architectural PC register and next-PC selection.
//   clk, rst  : clock, asynchronous active-high reset (PC <= RESET_PC)
//   pc_load   : load load_pc (low two bits cleared); has priority over pc_inc
//   load_pc   : redirect target
//   pc_inc    : advance PC by 4, wrapping modulo 2^ADDR_W
//   pc        : current PC
module ysyx_220053_pc_gen
    import ysyx_220053_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              pc_inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            // No compressed instructions: targets are always word aligned.
            pc_d = {load_pc[ADDR_W-1:2], 2'b00};
        end else if (pc_inc) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one request in flight
// to instruction memory and hands one instruction + PC to the decoder per
// handshake. Redirects from execute squash any wrong-path fetch.
//   clk, rst                          : clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr   : fetch request channel (addr = pc)
//   imem_resp_valid, imem_resp_data   : fetch response (single-cycle pulse)
//   redirect_valid, redirect_pc       : new PC from execute (single-cycle pulse)
//   out_valid/ready, instr_o, pc_o    : instruction channel to the decoder
module ysyx_220053_ifu
    import ysyx_220053_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    fetch_state_t      state_q, state_d;
    logic              drop_q, drop_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_o_q, pc_o_d;

    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;

    ysyx_220053_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk     (clk),
        .rst     (rst),
        .pc_load (pc_load),
        .load_pc (redirect_pc),
        .pc_inc  (pc_inc),
        .pc      (pc)
    );

    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        instr_d        = instr_q;
        pc_o_d         = pc_o_q;
        pc_load        = 1'b0;
        pc_inc         = 1'b0;
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                // A redirect suppresses the request so the stale PC is never
                // issued, even when memory would have accepted it.
                imem_req_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_resp_valid) begin
                    // Any response ends the outstanding request; drop never
                    // needs to survive it since only one request is in flight.
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                    end else if (!drop_q) begin
                        instr_d = imem_resp_data;
                        pc_o_d  = pc;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_load = 1'b1;
                    drop_d  = 1'b1;
                end
            end

            S_HOLD: begin
                // Redirect wins over the decoder handshake.
                out_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = S_REQ;
                end else if (out_ready) begin
                    pc_inc  = 1'b1;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            instr_q <= INST_NOP;
            pc_o_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            pc_o_q  <= pc_o_d;
        end
    end

    assign imem_addr = pc;
    assign instr_o   = instr_q;
    assign pc_o      = pc_o_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Bench for ysyx_220053_ifu: a transaction-level memory and architectural
// PC model (a plain "next expected PC" plus a one-slot memory) driven by
// directed scenarios followed by randomized traffic.
module tb_ysyx_220053_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_o;
    logic [63:0] pc_o;

    ysyx_220053_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .instr_o         (instr_o),
        .pc_o            (pc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    // Stimulus knobs
    int          rdy_pct   = 100;
    int          ordy_pct  = 100;
    int          dmin      = 1;
    int          dmax      = 1;
    int          spur_pct  = 0;
    int          redir_pct = 0;
    bit          redir_now = 1'b0;
    logic [63:0] redir_tgt = '0;

    // Model state
    logic [63:0] m_pc = RST_PC;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [63:0] paddr = '0;
    bit          held_v = 1'b0;
    logic [63:0] held_pc;
    logic [31:0] held_ins;

    // Observations
    int          cyc = 0;
    int          n_acc = 0;
    int          n_con = 0;
    int          idle_cnt = 0;
    bit          last_ov = 1'b0;
    logic [63:0] last_acc = '0;
    logic [63:0] last_con_pc = '0;
    logic [63:0] acc_log[$];
    int          acc_cyc[$];
    int          con_cyc[$];

    function automatic logic [63:0] rand_target();
        case ($urandom_range(2))
            0:       return {$urandom, $urandom};
            1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            default: return RST_PC + 64'($urandom_range(255));
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample the
    // settled outputs, and advance the model by what the next rising edge does.
    task automatic cycle();
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (pend) begin
            if (pcnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(paddr);
                pend = 1'b0;
            end else begin
                pcnt--;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            imem_resp_valid = 1'b1;
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ordy_pct);
        redirect_valid = redir_now || ($urandom_range(99) < redir_pct);
        redirect_pc    = redir_now ? redir_tgt : rand_target();
        redir_now      = 1'b0;
        #1;

        if (held_v && out_valid) begin
            check("hold_pc_stable", pc_o, held_pc);
            check("hold_instr_stable", 64'(instr_o), 64'(held_ins));
        end
        held_v = 1'b0;
        if (out_valid) check("no_req_in_hold", 64'(imem_req_valid), 64'd0);
        if (redirect_valid) begin
            check("redir_blocks_req", 64'(imem_req_valid), 64'd0);
            check("redir_blocks_out", 64'(out_valid), 64'd0);
        end

        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_addr, m_pc);
            check("one_outstanding", 64'(pend), 64'd0);
            n_acc++;
            last_acc = imem_addr;
            acc_log.push_back(imem_addr);
            acc_cyc.push_back(cyc);
            pend  = 1'b1;
            pcnt  = $urandom_range(dmax, dmin) - 1;
            paddr = imem_addr;
            idle_cnt = 0;
        end

        if (out_valid && out_ready) begin
            $display("[%0d] issue pc=%h instr=%h", cyc, pc_o, instr_o);
            check("out_pc", pc_o, m_pc);
            check("out_instr", 64'(instr_o), 64'(mem_word(m_pc)));
            n_con++;
            last_con_pc = pc_o;
            con_cyc.push_back(cyc);
            m_pc = m_pc + 64'd4;
            idle_cnt = 0;
        end else if (out_valid) begin
            held_v   = 1'b1;
            held_pc  = pc_o;
            held_ins = instr_o;
        end

        if (redirect_valid) m_pc = {redirect_pc[63:2], 2'b00};
        last_ov = out_valid;

        idle_cnt++;
        if (idle_cnt > 100) begin
            check("liveness", 64'(idle_cnt), 64'd0);
            idle_cnt = 0;
        end
        cyc++;
    endtask

    // Reset asserted between clock edges; outputs must follow immediately.
    task automatic do_reset(input int n, input bit stale);
        @(negedge clk);
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        out_ready       = 1'b0;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_pc_o", pc_o, RST_PC);
        check("rst_instr_o", 64'(instr_o), 64'(NOP));
        repeat (n) @(negedge clk);
        rst = 1'b0;
        // Optionally present a leftover response in the first cycle after release.
        imem_resp_valid = stale;
        imem_resp_data  = 32'hDEAD_BEEF;
        pend     = 1'b0;
        held_v   = 1'b0;
        m_pc     = RST_PC;
        idle_cnt = 0;
        last_ov  = 1'b0;
    endtask

    // what: 0 = next accept, 1 = next consume, 2 = request outstanding, 3 = out_valid seen
    task automatic run_until(input int what, input string tag);
        int  a0 = n_acc;
        int  c0 = n_con;
        bit  done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            case (what)
                0:       done = (n_acc > a0);
                1:       done = (n_con > c0);
                2:       done = pend;
                default: done = last_ov;
            endcase
        end
        if (!done) check({"timeout_", tag}, 64'd1, 64'd0);
    endtask

    task automatic set_knobs(input int rp, input int op, input int lo, input int hi);
        rdy_pct  = rp;
        ordy_pct = op;
        dmin     = lo;
        dmax     = hi;
    endtask

    initial begin
        int a0, c0;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        out_ready       = 1'b0;
        repeat (2) @(posedge clk);

        // Back-to-back fetch with an always-ready memory and decoder.
        set_knobs(100, 100, 1, 1);
        do_reset(2, 1'b0);
        acc_log.delete(); acc_cyc.delete(); con_cyc.delete();
        for (int i = 0; i < 3; i++) run_until(1, "stream");
        if (acc_log.size() >= 3 && con_cyc.size() >= 3) begin
            check("stream_addr0", acc_log[0], 64'h8000_0000);
            check("stream_addr1", acc_log[1], 64'h8000_0004);
            check("stream_addr2", acc_log[2], 64'h8000_0008);
            check("stream_latency", 64'(con_cyc[0] - acc_cyc[0]), 64'd2);
            check("stream_period1", 64'(con_cyc[1] - con_cyc[0]), 64'd3);
            check("stream_period2", 64'(con_cyc[2] - con_cyc[1]), 64'd3);
        end else begin
            check("stream_count", 64'(con_cyc.size()), 64'd3);
        end

        // Decoder back-pressure for 10 cycles.
        set_knobs(100, 0, 1, 1);
        do_reset(1, 1'b0);
        run_until(3, "bp_first_valid");
        a0 = n_acc;
        repeat (10) cycle();
        check("bp_no_request", 64'(n_acc - a0), 64'd0);
        check("bp_still_valid", 64'(last_ov), 64'd1);
        ordy_pct = 100;
        run_until(0, "bp_next_req");
        check("bp_next_addr", last_acc, 64'h8000_0004);

        // Redirect while waiting for a slow response: that response is dropped.
        set_knobs(100, 100, 3, 3);
        do_reset(1, 1'b0);
        run_until(2, "wait_req");
        redir_now = 1'b1;
        redir_tgt = 64'h8000_1002;
        run_until(1, "wait_redir_out");
        check("wait_redir_pc", last_con_pc, 64'h8000_1000);
        check("wait_redir_acc", last_acc, 64'h8000_1000);

        // Redirect in the same cycle the decoder would consume.
        set_knobs(100, 0, 1, 1);
        do_reset(1, 1'b0);
        run_until(3, "hold_valid");
        c0 = n_con;
        ordy_pct  = 100;
        redir_now = 1'b1;
        redir_tgt = 64'h8000_2000;
        cycle();
        check("hold_redir_no_consume", 64'(n_con - c0), 64'd0);
        run_until(0, "hold_redir_req");
        check("hold_redir_addr", last_acc, 64'h8000_2000);

        // Redirect while requesting with memory ready.
        set_knobs(0, 100, 1, 1);
        do_reset(1, 1'b0);
        cycle();
        a0 = n_acc;
        rdy_pct   = 100;
        redir_now = 1'b1;
        redir_tgt = 64'h8000_3008;
        cycle();
        check("req_redir_suppressed", 64'(n_acc - a0), 64'd0);
        cycle();
        check("req_redir_next", 64'(n_acc - a0), 64'd1);
        check("req_redir_addr", last_acc, 64'h8000_3008);

        // Reset while waiting; stale responses after release are ignored.
        set_knobs(100, 100, 3, 3);
        do_reset(1, 1'b0);
        run_until(2, "stale_req");
        do_reset(2, 1'b1);
        set_knobs(0, 100, 1, 1);
        spur_pct = 100;
        cycle();
        check("stale_no_out", 64'(out_valid), 64'd0);
        spur_pct = 0;
        rdy_pct  = 100;
        run_until(0, "stale_restart");
        check("stale_restart_addr", last_acc, RST_PC);
        run_until(1, "stale_out");

        // PC wrap at the top of the address space (misaligned target).
        set_knobs(0, 100, 1, 1);
        do_reset(1, 1'b0);
        cycle();
        rdy_pct   = 100;
        redir_now = 1'b1;
        redir_tgt = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        run_until(1, "wrap_out");
        check("wrap_pc", last_con_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        run_until(0, "wrap_req");
        check("wrap_addr", last_acc, 64'h0);

        // Randomized traffic.
        do_reset(1, 1'b0);
        spur_pct  = 5;
        redir_pct = 6;
        for (int i = 0; i < 2500; i++) begin
            if (i % 50 == 0)
                set_knobs($urandom_range(100, 30), $urandom_range(100, 30), 1, $urandom_range(4, 1));
            if ($urandom_range(999) < 3) do_reset(1, 1'b0);
            cycle();
        end
        redir_pct = 0;
        spur_pct  = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
